ahb_dbg_arbiter: RTL and testbench
==================================

# ahb_dbg_arbiter

Two-master AHB arbiter and bus multiplexer. It shares the single AHB slave port between the UART debugger master (`debugger_top`, M0) and the core's AHB master (M1). The block issues per-master grants, steers the address and write-data phases from the owning master to the slave, and returns slave HREADY/HRDATA/HRESP to both masters. It sits between the masters and `ahb_gen_slave` (or the decoder in front of it).

## Interface
- `DBG_MAX_XFERS`, default 16: maximum consecutive accepted debugger transfers while the core is requesting, before the core is given priority once.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous reset, active-high.
- `M0_HBUSREQ`, `M1_HBUSREQ`  in  1 each  bus request (M0 = debugger, M1 = core).
- `M0_HLOCK`, `M1_HLOCK`  in  1 each  locked-sequence request.
- `Mx_HTRANS`  in  2; `Mx_HADDR`  in  32; `Mx_HWRITE`  in  1; `Mx_HSIZE`  in  3; `Mx_HBURST`  in  3; `Mx_HWDATA`  in  32; `Mx_HPROT`  in  4  per-master AHB master signals.
- `M0_HGRANT`, `M1_HGRANT`  out  1 each  registered grant.
- `HTRANS` `HADDR` `HWRITE` `HSIZE` `HBURST` `HPROT`  out  to slave; mux of address owner.
- `HWDATA`  out  32  to slave; mux of data owner.
- `HMASTER`  out  1  current address owner (0 = M0, 1 = M1).
- `HMASTLOCK`  out  1  address owner's HLOCK.
- `HREADY`  in  1; `HRDATA`  in  32; `HRESP`  in  2  from slave; broadcast unchanged to both masters.

## Operation
- State: `grant` (1b), `addr_owner` (1b), `data_owner` (1b), `beats_left` (4b), `locked` (1b), `dbg_run` (count to DBG_MAX_XFERS), `core_prio` (1b).
- Address-side outputs are combinational muxes of the `addr_owner` master. HWDATA is the mux of the `data_owner` master.
- Burst length at NONSEQ acceptance:
  - SINGLE = 1
  - WRAP4/INCR4 = 4
  - WRAP8/INCR8 = 8
  - WRAP16/INCR16 = 16
  - INCR (undefined length) = held while the owner's HTRANS is SEQ or BUSY.
- `beats_left`:
  - loaded with len-1 on NONSEQ acceptance (HREADY=1);
  - decremented on SEQ acceptance;
  - cleared when the owner presents IDLE (early termination, e.g. after an ERROR response).
- `locked` is set to the owner's HLOCK on every accepted NONSEQ. It clears when the owner presents IDLE with HLOCK=0.
- Arbitration point: a cycle with HREADY=1 and not `locked`, and where, after this cycle's acceptance, `beats_left`=0 and the owner is not in an INCR burst.
- Winner at an arbitration point:
  - if `core_prio`=1 and M1 requests: M1;
  - else if M0 requests: M0;
  - else if M1 requests: M1;
  - else park on M1.
- `dbg_run` increments on each accepted M0 NONSEQ/SEQ while M1_HBUSREQ=1. It resets to 0 when M1_HBUSREQ=0 or M1 is granted.
- On reaching DBG_MAX_XFERS, `core_prio` sets. It clears once M1 has been granted.

## Timing
- Reset values:
  - `grant`=`addr_owner`=`data_owner`=1 (core); M1_HGRANT=1, M0_HGRANT=0, HMASTER=1;
  - `beats_left`=0, `locked`=0, `dbg_run`=0, `core_prio`=0;
  - slave-side outputs follow M1 combinationally.
- `grant` loads the winner on the rising edge ending an arbitration point. No grant change occurs in any cycle with HREADY=0.
- `addr_owner` <= `grant` on each edge with HREADY=1. The new owner's first address phase is the cycle after that edge.
- `data_owner` <= `addr_owner` on each edge with HREADY=1.
- Handover latency with the bus idle: request asserted in cycle N → grant at edge N+1 → address on the slave in cycle N+2.
- Simultaneous requests at an arbitration point: M0 wins unless `core_prio`=1.
- Bursts and locked sequences are never split. A request arriving mid-burst waits for the burst's last address acceptance.
- Reset mid-burst returns all state to reset values at the next edge. No beat completion is emitted afterwards.

## Test plan
- Reset: hold Rst=1 for 2 cycles → M1_HGRANT=1, HMASTER=1, HTRANS mirrors M1_HTRANS.
- Idle handover: M0_HBUSREQ=1 at cycle 5, HREADY=1 → M0_HGRANT=1 at cycle 6; M0 NONSEQ write 0x0000_0010 with data 0x0000_0004 → slave sees HADDR=0x10 at cycle 7 and HWDATA=4 at cycle 8.
- Burst protection: M1 issues INCR4 reads from 0x20; M0 requests during beat 2 → M1 completes 0x20, 0x24, 0x28, 0x2C; M0 granted only on the edge where 0x2C is accepted.
- Wait states: slave holds HREADY=0 for 3 cycles during an M0 read of 0x04 → grant, owners and HADDR stay frozen; HRDATA=0x1 returned on release.
- Lock: M0 issues a locked sequence of two SINGLEs with HLOCK=1 while M1 requests → no grant change until M0 presents IDLE with HLOCK=0; HMASTLOCK=1 throughout.
- Fairness: DBG_MAX_XFERS=4; M0 issues continuous SINGLEs with M1 requesting → M1 is granted after the 4th accepted M0 transfer; `core_prio` clears once M1 is granted.

Source files
------------

// File: rtl/ahb_dbg_arbiter.sv
// Two-master AHB arbiter and bus mux: shares one slave port between the UART debugger (M0)
// and the core (M1), never splitting bursts or locked sequences, with a debugger fairness limit.
module ahb_dbg_arbiter #(
   parameter int DBG_MAX_XFERS = 16
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        M0_HBUSREQ,
   input  logic        M1_HBUSREQ,
   input  logic        M0_HLOCK,
   input  logic        M1_HLOCK,
   input  logic [1:0]  M0_HTRANS,
   input  logic [31:0] M0_HADDR,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic [2:0]  M0_HBURST,
   input  logic [31:0] M0_HWDATA,
   input  logic [3:0]  M0_HPROT,
   input  logic [1:0]  M1_HTRANS,
   input  logic [31:0] M1_HADDR,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic [2:0]  M1_HBURST,
   input  logic [31:0] M1_HWDATA,
   input  logic [3:0]  M1_HPROT,
   output logic        M0_HGRANT,
   output logic        M1_HGRANT,
   output logic [1:0]  HTRANS,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [31:0] HWDATA,
   output logic        HMASTER,
   output logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   input  logic [1:0]  HRESP
);

   localparam int RUN_W = $clog2(DBG_MAX_XFERS + 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DBG_MAX_XFERS);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DBG_MAX_XFERS - 1);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;
   localparam logic [2:0] BURST_INCR   = 3'b001;

   logic             grant;
   logic             addr_owner;
   logic             data_owner;
   logic [3:0]       beats_left;
   logic             locked;
   logic [RUN_W-1:0] dbg_run;
   logic             core_prio;

   logic [3:0] len_m1;
   logic [3:0] beats_nxt;
   logic       locked_nxt;
   logic       incr_active;
   logic       m0_accept;
   logic       prio_hit;
   logic       arb_point;
   logic       winner;
   logic       unused_slave_rsp;

   assign HTRANS    = addr_owner ? M1_HTRANS : M0_HTRANS;
   assign HADDR     = addr_owner ? M1_HADDR  : M0_HADDR;
   assign HWRITE    = addr_owner ? M1_HWRITE : M0_HWRITE;
   assign HSIZE     = addr_owner ? M1_HSIZE  : M0_HSIZE;
   assign HBURST    = addr_owner ? M1_HBURST : M0_HBURST;
   assign HPROT     = addr_owner ? M1_HPROT  : M0_HPROT;
   assign HMASTLOCK = addr_owner ? M1_HLOCK  : M0_HLOCK;
   assign HWDATA    = data_owner ? M1_HWDATA : M0_HWDATA;
   assign HMASTER   = addr_owner;
   assign M0_HGRANT = ~grant;
   assign M1_HGRANT = grant;

   assign unused_slave_rsp = ^{HRDATA, HRESP};

   // Post-acceptance burst and lock state decide whether this cycle may hand the bus over
   always_comb begin
      len_m1     = 4'd0;
      beats_nxt  = beats_left;
      locked_nxt = locked;
      case (HBURST)
         3'b010, 3'b011: len_m1 = 4'd3;
         3'b100, 3'b101: len_m1 = 4'd7;
         3'b110, 3'b111: len_m1 = 4'd15;
         default:        len_m1 = 4'd0;
      endcase
      if (HREADY) begin
         if (HTRANS == TRANS_IDLE) begin
            beats_nxt = 4'd0;
            if (!HMASTLOCK) locked_nxt = 1'b0;
         end else if (HTRANS == TRANS_NONSEQ) begin
            beats_nxt  = len_m1;
            locked_nxt = HMASTLOCK;
         end else if (HTRANS == TRANS_SEQ && beats_left != 4'd0) begin
            beats_nxt = beats_left - 4'd1;
         end
      end
   end

   assign incr_active = (HBURST == BURST_INCR) && (HTRANS != TRANS_IDLE);
   assign arb_point   = HREADY && !locked_nxt && (beats_nxt == 4'd0) && !incr_active;
   assign m0_accept   = HREADY && HTRANS[1] && !addr_owner;
   assign prio_hit    = m0_accept && M1_HBUSREQ && !grant && (dbg_run == RUN_LAST);

   // The transfer that exhausts the debugger's run already hands priority to the core
   always_comb begin
      if ((core_prio || prio_hit) && M1_HBUSREQ) winner = 1'b1;
      else if (M0_HBUSREQ)                       winner = 1'b0;
      else                                       winner = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         grant      <= 1'b1;
         addr_owner <= 1'b1;
         data_owner <= 1'b1;
         beats_left <= 4'd0;
         locked     <= 1'b0;
         dbg_run    <= '0;
         core_prio  <= 1'b0;
      end else begin
         if (arb_point) grant <= winner;
         if (HREADY) begin
            addr_owner <= grant;
            data_owner <= addr_owner;
         end
         beats_left <= beats_nxt;
         locked     <= locked_nxt;
         if (!M1_HBUSREQ || grant) dbg_run <= '0;
         else if (m0_accept && dbg_run != RUN_MAX) dbg_run <= dbg_run + RUN_W'(1);
         core_prio <= (core_prio || prio_hit) && !grant;
      end
   end

endmodule

// File: tb/tb_ahb_dbg_arbiter.sv
// Self-checking bench for ahb_dbg_arbiter: scripted master behaviour per scenario, with a
// slave-side scoreboard that checks every accepted address phase and write data phase.
module tb_ahb_dbg_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_hbusreq, m1_hbusreq, m0_hlock, m1_hlock;
   logic [1:0]  m0_htrans, m1_htrans;
   logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
   logic        m0_hwrite, m1_hwrite;
   logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
   logic [3:0]  m0_hprot, m1_hprot;
   logic        m0_hgrant, m1_hgrant;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata;
   logic        hwrite, hmaster, hmastlock;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic        hready;
   logic [31:0] hrdata;
   logic [1:0]  hresp;

   typedef struct packed {
      logic        master;
      logic        write;
      logic [31:0] addr;
   } xfer_t;

   xfer_t       addr_q[$];
   logic [31:0] data_q[$];
   xfer_t       exp_x;
   logic        dp_valid = 1'b0;
   logic [31:0] dp_exp;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   ahb_dbg_arbiter #(.DBG_MAX_XFERS(4)) dut (
      .clk(clk), .Rst(rst),
      .M0_HBUSREQ(m0_hbusreq), .M1_HBUSREQ(m1_hbusreq),
      .M0_HLOCK(m0_hlock), .M1_HLOCK(m1_hlock),
      .M0_HTRANS(m0_htrans), .M0_HADDR(m0_haddr), .M0_HWRITE(m0_hwrite),
      .M0_HSIZE(m0_hsize), .M0_HBURST(m0_hburst), .M0_HWDATA(m0_hwdata), .M0_HPROT(m0_hprot),
      .M1_HTRANS(m1_htrans), .M1_HADDR(m1_haddr), .M1_HWRITE(m1_hwrite),
      .M1_HSIZE(m1_hsize), .M1_HBURST(m1_hburst), .M1_HWDATA(m1_hwdata), .M1_HPROT(m1_hprot),
      .M0_HGRANT(m0_hgrant), .M1_HGRANT(m1_hgrant),
      .HTRANS(htrans), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HPROT(hprot), .HWDATA(hwdata), .HMASTER(hmaster), .HMASTLOCK(hmastlock),
      .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp)
   );

   // Slave-side scoreboard: pops one expected address per accepted phase, then checks its write data
   always @(negedge clk) begin
      if (rst) begin
         dp_valid = 1'b0;
      end else begin
         if (dp_valid && hready) begin
            vectors++;
            if (hwdata !== dp_exp) begin
               miscompares++;
               $display("[TB] FAIL sb_wdata: got %h expected %h", hwdata, dp_exp);
            end
            dp_valid = 1'b0;
         end
         if (hready && htrans[1]) begin
            vectors++;
            if (addr_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL sb_unexpected: got addr %h master %b expected no transfer", haddr, hmaster);
            end else begin
               exp_x = addr_q.pop_front();
               if ({hmaster, hwrite, haddr} !== exp_x) begin
                  miscompares++;
                  $display("[TB] FAIL sb_addr: got m%b w%b %h expected m%b w%b %h",
                           hmaster, hwrite, haddr, exp_x.master, exp_x.write, exp_x.addr);
               end
               if (exp_x.write) begin
                  dp_exp   = (data_q.size() != 0) ? data_q.pop_front() : 32'hDEAD_BEEF;
                  dp_valid = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      m1_htrans = 2'b10;
      m1_haddr  = 32'h0000_ABC0;
      m0_haddr  = 32'h0000_5550;
      next_cycle();
      next_cycle();
      @(negedge clk);
      vectors++;
      if ({m1_hgrant, m0_hgrant, hmaster} !== 3'b101) begin
         miscompares++;
         $display("[TB] FAIL reset_grants: got %b expected 101", {m1_hgrant, m0_hgrant, hmaster});
      end
      vectors++;
      if ({htrans, haddr} !== {2'b10, 32'h0000_ABC0}) begin
         miscompares++;
         $display("[TB] FAIL reset_mirror: got %b %h expected 10 0000abc0", htrans, haddr);
      end
      next_cycle();
      m1_htrans = 2'b11;
      @(negedge clk);
      vectors++;
      if (htrans !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL reset_mirror_seq: got %b expected 11", htrans);
      end
      next_cycle();
      rst = 1'b0;
      m1_htrans = 2'b00;
      m1_haddr  = 32'h0;
      m0_haddr  = 32'h0;
      @(negedge clk);
      vectors++;
      if (m1_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_park: got %b expected 1", m1_hgrant);
      end
   endtask

   task automatic test_idle_handover;
      next_cycle();
      m0_hbusreq = 1'b1;
      @(negedge clk);
      vectors++;
      if (m0_hgrant !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL handover_early: got %b expected 0", m0_hgrant);
      end
      next_cycle();
      @(negedge clk);
      vectors++;
      if ({m0_hgrant, m1_hgrant, hmaster} !== 3'b101) begin
         miscompares++;
         $display("[TB] FAIL handover_grant: got %b expected 101", {m0_hgrant, m1_hgrant, hmaster});
      end
      next_cycle();
      m0_htrans = 2'b10; m0_hwrite = 1'b1; m0_haddr = 32'h0000_0010;
      m0_hbusreq = 1'b0;
      addr_q.push_back('{master: 1'b0, write: 1'b1, addr: 32'h0000_0010});
      data_q.push_back(32'h0000_0004);
      @(negedge clk);
      vectors++;
      if (hmaster !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL handover_owner: got %b expected 0", hmaster);
      end
      next_cycle();
      m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_haddr = 32'h0;
      m0_hwdata = 32'h0000_0004;
      @(negedge clk);
      vectors++;
      if ({m0_hgrant, hmaster} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL handover_park: got %b expected 00", {m0_hgrant, hmaster});
      end
      next_cycle();
      m0_hwdata = 32'h0;
      @(negedge clk);
      vectors++;
      if (hmaster !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL handover_return: got %b expected 1", hmaster);
      end
   endtask

   task automatic test_burst;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         m1_hbusreq = (i < 3);
         m1_htrans  = (i == 0) ? 2'b10 : 2'b11;
         m1_hburst  = 3'b011;
         m1_haddr   = 32'h20 + 32'(4 * i);
         if (i == 1) m0_hbusreq = 1'b1;
         addr_q.push_back('{master: 1'b1, write: 1'b0, addr: 32'h20 + 32'(4 * i)});
         @(negedge clk);
         vectors++;
         if (m0_hgrant !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL burst_split beat %0d: got %b expected 0", i, m0_hgrant);
         end
      end
      next_cycle();
      m1_htrans = 2'b00; m1_hburst = 3'b000; m1_haddr = 32'h0;
      @(negedge clk);
      vectors++;
      if ({m0_hgrant, hmaster} !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL burst_handover: got %b expected 11", {m0_hgrant, hmaster});
      end
   endtask

   task automatic test_wait_states;
      next_cycle();
      m0_htrans = 2'b10; m0_haddr = 32'h04;
      addr_q.push_back('{master: 1'b0, write: 1'b0, addr: 32'h04});
      @(negedge clk);
      vectors++;
      if (hmaster !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wait_owner: got %b expected 0", hmaster);
      end
      next_cycle();
      m0_haddr = 32'h08; m0_hbusreq = 1'b0; m1_hbusreq = 1'b1; hready = 1'b0;
      addr_q.push_back('{master: 1'b0, write: 1'b0, addr: 32'h08});
      for (int i = 0; i < 3; i++) begin
         if (i > 0) next_cycle();
         @(negedge clk);
         vectors++;
         if ({m0_hgrant, hmaster, haddr} !== {1'b1, 1'b0, 32'h08}) begin
            miscompares++;
            $display("[TB] FAIL wait_frozen %0d: got %b %b %h expected 1 0 00000008",
                     i, m0_hgrant, hmaster, haddr);
         end
      end
      next_cycle();
      hready = 1'b1; hrdata = 32'h1;
      @(negedge clk);
      vectors++;
      if (m0_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wait_release: got %b expected 1", m0_hgrant);
      end
      next_cycle();
      m0_htrans = 2'b00; m0_haddr = 32'h0; hrdata = 32'h0;
      @(negedge clk);
      vectors++;
      if ({m1_hgrant, hmaster} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL wait_to_core: got %b expected 10", {m1_hgrant, hmaster});
      end
      next_cycle();
   endtask

   task automatic test_lock;
      next_cycle();
      m0_hbusreq = 1'b1; m0_hlock = 1'b1;
      next_cycle();
      @(negedge clk);
      vectors++;
      if (m0_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lock_grant: got %b expected 1", m0_hgrant);
      end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         m0_hbusreq = 1'b0;
         m0_htrans = 2'b10; m0_hwrite = 1'b1; m0_haddr = 32'h40 + 32'(4 * i);
         m0_hwdata = (i == 1) ? 32'hAA : 32'h0;
         addr_q.push_back('{master: 1'b0, write: 1'b1, addr: 32'h40 + 32'(4 * i)});
         data_q.push_back((i == 0) ? 32'hAA : 32'hBB);
         @(negedge clk);
         vectors++;
         if ({m0_hgrant, hmaster, hmastlock} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL lock_hold %0d: got %b expected 101", i, {m0_hgrant, hmaster, hmastlock});
         end
      end
      next_cycle();
      m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_haddr = 32'h0; m0_hlock = 1'b0;
      m0_hwdata = 32'hBB;
      @(negedge clk);
      vectors++;
      if (m0_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lock_idle_cycle: got %b expected 1", m0_hgrant);
      end
      next_cycle();
      m0_hwdata = 32'h0;
      @(negedge clk);
      vectors++;
      if (m1_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lock_release: got %b expected 1", m1_hgrant);
      end
   endtask

   task automatic test_fairness;
      next_cycle();
      m0_hbusreq = 1'b1; m1_hbusreq = 1'b1;
      next_cycle();
      @(negedge clk);
      vectors++;
      if (m0_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL fair_first_grant: got %b expected 1", m0_hgrant);
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         m0_htrans = 2'b10; m0_haddr = 32'h100 + 32'(4 * i);
         addr_q.push_back('{master: 1'b0, write: 1'b0, addr: 32'h100 + 32'(4 * i)});
         @(negedge clk);
         vectors++;
         if ({m0_hgrant, dut.core_prio} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL fair_run %0d: got %b expected 10", i, {m0_hgrant, dut.core_prio});
         end
      end
      next_cycle();
      m0_htrans = 2'b00; m0_haddr = 32'h0;
      @(negedge clk);
      vectors++;
      if ({m1_hgrant, dut.core_prio} !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL fair_core_grant: got %b expected 11", {m1_hgrant, dut.core_prio});
      end
      next_cycle();
      @(negedge clk);
      vectors++;
      if ({m1_hgrant, dut.core_prio} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL fair_prio_clear: got %b expected 10", {m1_hgrant, dut.core_prio});
      end
      next_cycle();
      @(negedge clk);
      vectors++;
      if (m0_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL fair_back_to_dbg: got %b expected 1", m0_hgrant);
      end
   endtask

   task automatic test_reset_mid_burst;
      next_cycle();
      m0_htrans = 2'b10; m0_hburst = 3'b101; m0_haddr = 32'h200;
      addr_q.push_back('{master: 1'b0, write: 1'b0, addr: 32'h200});
      @(negedge clk);
      vectors++;
      if (hmaster !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rstburst_owner: got %b expected 0", hmaster);
      end
      next_cycle();
      rst = 1'b1;
      m0_htrans = 2'b11; m0_haddr = 32'h204;
      next_cycle();
      rst = 1'b0;
      m0_haddr = 32'h208;
      @(negedge clk);
      vectors++;
      if ({m1_hgrant, m0_hgrant, hmaster, htrans} !== 5'b10100) begin
         miscompares++;
         $display("[TB] FAIL rstburst_state: got %b expected 10100", {m1_hgrant, m0_hgrant, hmaster, htrans});
      end
      next_cycle();
      m0_htrans = 2'b00; m0_hburst = 3'b000; m0_haddr = 32'h0;
      m0_hbusreq = 1'b0; m1_hbusreq = 1'b0;
      @(negedge clk);
      vectors++;
      if (m0_hgrant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rstburst_rearb: got %b expected 1", m0_hgrant);
      end
      next_cycle();
      next_cycle();
      @(negedge clk);
      vectors++;
      if (addr_q.size() + data_q.size() != 0 || dp_valid) begin
         miscompares++;
         $display("[TB] FAIL sb_drain: got %0d pending expected 0", addr_q.size() + data_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      m0_hbusreq = 1'b0; m1_hbusreq = 1'b0; m0_hlock = 1'b0; m1_hlock = 1'b0;
      m0_htrans = 2'b00; m1_htrans = 2'b00; m0_haddr = 32'h0; m1_haddr = 32'h0;
      m0_hwrite = 1'b0; m1_hwrite = 1'b0; m0_hsize = 3'b010; m1_hsize = 3'b010;
      m0_hburst = 3'b000; m1_hburst = 3'b000; m0_hwdata = 32'h0; m1_hwdata = 32'h0;
      m0_hprot = 4'h1; m1_hprot = 4'h3;
      hready = 1'b1; hrdata = 32'h0; hresp = 2'b00;
      test_reset();
      test_idle_handover();
      test_burst();
      test_wait_states();
      test_lock();
      test_fairness();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
